ml_cmd_ctrl: RTL and testbench
==============================

# ml_cmd_ctrl

Command sequencer behind the ML serial interface's byte deserializer. It consumes the assembled byte stream one frame at a time, where a frame is one chip-select assertion. It decodes an opcode plus address header, drives byte writes into the accelerator memory with address auto-increment, and issues run requests to the compute engine. It owns the `ml_rdy` and `ml_err` pins, which the front end currently ties low.

## Interface

- `ADDR_W`, default 16: memory address width, 1..16. Header address bits above `ADDR_W` are ignored.

- `clock`  in  1  system clock; all logic on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `frame_active`  in  1  synchronized chip-select; 1 = frame in progress (csb low)
- `din_valid`  in  1  single-cycle strobe; `din_data` valid
- `din_data`  in  8  received byte
- `mem_wen`  out  1  write request; held until accepted
- `mem_addr`  out  ADDR_W  write address
- `mem_wdata`  out  8  write data
- `mem_ready`  in  1  write accepted this cycle when `mem_wen`=1
- `run_start`  out  1  one-cycle pulse: start engine
- `run_addr`  out  ADDR_W  engine entry address; stable while busy
- `engine_done`  in  1  one-cycle pulse: engine finished
- `ml_rdy`  out  1  1 = engine idle (not busy)
- `ml_err`  out  1  sticky error flag

## Operation

- Opcodes, decoded from the first byte of a frame:
  - 0x00 NOP: remaining bytes are discarded, no error.
  - 0x20 WRITE: ADDR_HI, ADDR_LO, then data bytes.
  - 0x21 RUN: ADDR_HI, ADDR_LO.
  - 0x22 CLEAR_ERR: clears `ml_err`.
- FSM states:
  - IDLE waits for the opcode:
    - WRITE or RUN → ADDR_HI.
    - NOP or CLEAR_ERR → DISCARD.
    - Any other byte → set err, go to DISCARD.
  - ADDR_HI latches the high byte → ADDR_LO.
  - ADDR_LO latches the low byte. Address = {hi,lo}[ADDR_W-1:0].
    - For WRITE → DATA.
    - For RUN: load `run_addr`, pulse `run_start`, set busy → DISCARD_ERR.
  - DATA: each byte issues one write at the current address, then the address increments modulo 2^ADDR_W (0xFFFF → 0x0000 when ADDR_W=16).
  - DISCARD ignores bytes.
  - DISCARD_ERR: any further byte sets err.
- `frame_active`=0 forces IDLE from every state in the next cycle.
  - A truncated header is dropped silently, with no write and no run.
  - A write already pending still completes.
- Busy: set by `run_start`, cleared by `engine_done`. `ml_rdy` = !busy.
  - WRITE or RUN opcode while busy: set err, go to DISCARD. No write or run occurs.
  - NOP and CLEAR_ERR are legal while busy.
- Write handshake uses a single-entry holding register.
  - `mem_wen` rises the cycle after the data byte's `din_valid`.
  - `mem_addr`/`mem_wdata` hold until the cycle `mem_ready`=1. `mem_wen` drops in the next cycle unless a new byte is loaded.
  - A data byte that arrives while a write is still pending (`mem_wen`=1 and `mem_ready`=0 in that cycle) is dropped and sets err. The address does not advance.
  - A byte that arrives in the same cycle the pending write is accepted is loaded normally, so back-to-back writes are allowed.
- `ml_err`:
  - Once set, it stays set until a CLEAR_ERR opcode byte.
  - If a set condition and a clear occur in the same cycle, set wins.
- `engine_done` while not busy is ignored.
- `run_start` and `engine_done` in the same cycle: busy stays 1. The new run wins.

## Timing

- Reset values:
  - `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0.
  - `run_start`=0, `run_addr`=0.
  - `ml_rdy`=1, `ml_err`=0.
  - FSM in IDLE, busy=0.
- Reset asserted mid-frame or mid-write drops everything immediately, including a pending `mem_wen`.
- Latencies, all counted from the cycle with `din_valid`=1:
  - Data byte to `mem_wen`: 1 cycle.
  - RUN ADDR_LO to `run_start`: 1 cycle. `ml_rdy` falls in that same cycle.
  - Opcode error to `ml_err`=1: 1 cycle.
  - `engine_done` to `ml_rdy`=1: 1 cycle.
- `din_valid` strobes are at least 2 cycles apart, guaranteed by the front end. Bytes are accepted only while `frame_active`=1.
- All outputs are registered.

## Test plan

- WRITE frame 0x20,0x01,0x00,0xAA,0xBB,0xCC with `mem_ready` tied to 1 → three writes (0x0100,0xAA), (0x0101,0xBB), (0x0102,0xCC). Each `mem_wen` is 1 cycle wide. `ml_err`=0.
- WRITE at 0xFFFF with 2 data bytes, ADDR_W=16 → writes to 0xFFFF, then 0x0000. With ADDR_W=12 and header 0xFFFF → writes to 0xFFF, then 0x000.
- RUN 0x21,0x12,0x34 → `run_start` pulse, `run_addr`=0x1234, `ml_rdy`=0. Then:
  - A WRITE frame while busy → no `mem_wen`, `ml_err`=1.
  - `engine_done` → `ml_rdy`=1.
  - Frame 0x22 → `ml_err`=0.
- Hold `mem_ready`=0 for 10 cycles during a 3-data-byte WRITE → first write held stable, the second byte is dropped, `ml_err`=1. After `mem_ready`=1, the third byte is written to base+1.
- Error cases:
  - Opcode 0x7F → `ml_err`=1, later bytes in the frame are ignored.
  - WRITE header truncated after ADDR_HI by a frame end → next frame 0x20,0x00,0x10,0x55 writes (0x0010,0x55).
  - RUN frame with a trailing byte → `ml_err`=1.
- Assert `resetn` low in the middle of a pending write and mid-RUN busy → all outputs return to their reset values asynchronously. The next frame decodes normally.

Source files
------------

// File: rtl/ml_cmd_ctrl.sv
// Frame-based command sequencer: decodes opcode/address headers from the deserialized
// byte stream, issues auto-incrementing memory writes and engine run requests.
module ml_cmd_ctrl #(
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              frame_active,
   input  logic              din_valid,
   input  logic [7:0]        din_data,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ready,
   output logic              run_start,
   output logic [ADDR_W-1:0] run_addr,
   input  logic              engine_done,
   output logic              ml_rdy,
   output logic              ml_err
);

   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_WRITE = 8'h20;
   localparam logic [7:0] OP_RUN   = 8'h21;
   localparam logic [7:0] OP_CLR   = 8'h22;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_HI,
      S_ADDR_LO,
      S_DATA,
      S_DISCARD,
      S_DISCARD_ERR
   } state_e;

   state_e            state_q, state_d;
   logic              is_run_q, is_run_d;
   logic [7:0]        hi_q, hi_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic              mem_wen_q, mem_wen_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_wdata_q, mem_wdata_d;
   logic              run_start_q, run_start_d;
   logic [ADDR_W-1:0] run_addr_q, run_addr_d;
   logic              rdy_q, rdy_d;
   logic              err_q, err_d;

   logic              err_set;
   logic              err_clr;
   logic              wr_pend;
   logic [15:0]       hdr_addr;

   assign hdr_addr = {hi_q, din_data};
   // Holding register still owns the bus: a new data byte cannot be loaded.
   assign wr_pend  = mem_wen_q & ~mem_ready;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         is_run_q    <= 1'b0;
         hi_q        <= 8'h00;
         waddr_q     <= '0;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'h00;
         run_start_q <= 1'b0;
         run_addr_q  <= '0;
         rdy_q       <= 1'b1;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_run_q    <= is_run_d;
         hi_q        <= hi_d;
         waddr_q     <= waddr_d;
         mem_wen_q   <= mem_wen_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         run_start_q <= run_start_d;
         run_addr_q  <= run_addr_d;
         rdy_q       <= rdy_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      is_run_d    = is_run_q;
      hi_d        = hi_q;
      waddr_d     = waddr_q;
      mem_wen_d   = mem_wen_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      run_start_d = 1'b0;
      run_addr_d  = run_addr_q;
      rdy_d       = rdy_q;
      err_set     = 1'b0;
      err_clr     = 1'b0;

      if (mem_wen_q && mem_ready) begin
         mem_wen_d = 1'b0;
      end

      // A run launched below overrides this, so a coincident done keeps busy set.
      if (engine_done) begin
         rdy_d = 1'b1;
      end

      if (!frame_active) begin
         state_d = S_IDLE;
      end else if (din_valid) begin
         case (state_q)
            S_IDLE: begin
               case (din_data)
                  OP_WRITE, OP_RUN: begin
                     if (!rdy_q) begin
                        err_set = 1'b1;
                        state_d = S_DISCARD;
                     end else begin
                        is_run_d = (din_data == OP_RUN);
                        state_d  = S_ADDR_HI;
                     end
                  end
                  OP_NOP: state_d = S_DISCARD;
                  OP_CLR: begin
                     err_clr = 1'b1;
                     state_d = S_DISCARD;
                  end
                  default: begin
                     err_set = 1'b1;
                     state_d = S_DISCARD;
                  end
               endcase
            end
            S_ADDR_HI: begin
               hi_d    = din_data;
               state_d = S_ADDR_LO;
            end
            S_ADDR_LO: begin
               if (is_run_q) begin
                  run_addr_d  = ADDR_W'(hdr_addr);
                  run_start_d = 1'b1;
                  rdy_d       = 1'b0;
                  state_d     = S_DISCARD_ERR;
               end else begin
                  waddr_d = ADDR_W'(hdr_addr);
                  state_d = S_DATA;
               end
            end
            S_DATA: begin
               if (wr_pend) begin
                  err_set = 1'b1;
               end else begin
                  mem_wen_d   = 1'b1;
                  mem_addr_d  = waddr_q;
                  mem_wdata_d = din_data;
                  waddr_d     = waddr_q + ADDR_W'(1);
               end
            end
            S_DISCARD: begin
               state_d = S_DISCARD;
            end
            S_DISCARD_ERR: begin
               err_set = 1'b1;
            end
            default: state_d = S_IDLE;
         endcase
      end

      err_d = err_set | (err_q & ~err_clr);
   end

   assign mem_wen   = mem_wen_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign run_start = run_start_q;
   assign run_addr  = run_addr_q;
   assign ml_rdy    = rdy_q;
   assign ml_err    = err_q;

endmodule

// File: tb/tb_ml_cmd_ctrl.sv
// Directed bench for ml_cmd_ctrl: 16-bit and 12-bit address instances share stimulus.
module tb_ml_cmd_ctrl;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   logic        clock = 1'b0;
   logic        resetn;
   logic        frame_active;
   logic        din_valid;
   logic [7:0]  din_data;
   logic        mem_ready;
   logic        engine_done;

   logic        mem_wen;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        run_start;
   logic [15:0] run_addr;
   logic        ml_rdy;
   logic        ml_err;

   logic        w12_wen;
   logic [11:0] w12_addr;
   logic [7:0]  w12_wdata;
   logic        w12_run_start;
   logic [11:0] w12_run_addr;
   logic        w12_rdy;
   logic        w12_err;

   int checks   = 0;
   int failures = 0;
   int wen_cycles = 0;
   int base;
   wr_t wq16[$];
   wr_t wq12[$];

   ml_cmd_ctrl #(.ADDR_W(16)) dut (
      .clock(clock), .resetn(resetn), .frame_active(frame_active),
      .din_valid(din_valid), .din_data(din_data),
      .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
      .run_start(run_start), .run_addr(run_addr), .engine_done(engine_done),
      .ml_rdy(ml_rdy), .ml_err(ml_err)
   );

   ml_cmd_ctrl #(.ADDR_W(12)) dut12 (
      .clock(clock), .resetn(resetn), .frame_active(frame_active),
      .din_valid(din_valid), .din_data(din_data),
      .mem_wen(w12_wen), .mem_addr(w12_addr), .mem_wdata(w12_wdata), .mem_ready(mem_ready),
      .run_start(w12_run_start), .run_addr(w12_run_addr), .engine_done(engine_done),
      .ml_rdy(w12_rdy), .ml_err(w12_err)
   );

   always #5 clock = ~clock;

   // Accepted writes are those with wen and ready both high going into a rising edge.
   always @(negedge clock) begin
      if (resetn && mem_wen) wen_cycles++;
      if (resetn && mem_wen && mem_ready) wq16.push_back({mem_addr, mem_wdata});
      if (resetn && w12_wen && mem_ready) wq12.push_back({4'h0, w12_addr, w12_wdata});
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      din_valid = 1'b1;
      din_data  = b;
      tick();
      din_valid = 1'b0;
      tick();
   endtask

   task automatic frame_open();
      frame_active = 1'b1;
      tick();
   endtask

   task automatic frame_close();
      frame_active = 1'b0;
      tick();
      tick();
   endtask

   task automatic frame(input int n, input logic [7:0] b0 = 8'h00, input logic [7:0] b1 = 8'h00,
                        input logic [7:0] b2 = 8'h00, input logic [7:0] b3 = 8'h00,
                        input logic [7:0] b4 = 8'h00, input logic [7:0] b5 = 8'h00);
      logic [7:0] bb [6];
      bb = '{b0, b1, b2, b3, b4, b5};
      frame_open();
      for (int i = 0; i < n; i++) send(bb[i]);
      frame_close();
   endtask

   task automatic clear_q();
      wq16.delete();
      wq12.delete();
      base = wen_cycles;
   endtask

   task automatic exp_wr16(input string tag, input int i, input logic [15:0] a, input logic [7:0] d);
      chk(tag, 32'(wq16[i]), {8'h00, a, d});
   endtask

   task automatic exp_wr12(input string tag, input int i, input logic [15:0] a, input logic [7:0] d);
      chk(tag, 32'(wq12[i]), {8'h00, a, d});
   endtask

   task automatic pulse_done();
      engine_done = 1'b1;
      tick();
      engine_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn       = 1'b0;
      frame_active = 1'b0;
      din_valid    = 1'b0;
      din_data     = 8'h00;
      mem_ready    = 1'b1;
      engine_done  = 1'b0;
      repeat (3) tick();
      chk("rst_wen",   mem_wen,   0);
      chk("rst_addr",  mem_addr,  0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_run",   run_start, 0);
      chk("rst_raddr", run_addr,  0);
      chk("rst_rdy",   ml_rdy,    1);
      chk("rst_err",   ml_err,    0);
      resetn = 1'b1;
      tick();

      // Basic write frame with an always-ready memory
      clear_q();
      frame_open();
      send(8'h20); send(8'h01); send(8'h00);
      din_valid = 1'b1; din_data = 8'hAA;
      tick();
      chk("t1_wen_lat", mem_wen, 1);
      chk("t1_addr_lat", mem_addr, 16'h0100);
      din_valid = 1'b0;
      tick();
      chk("t1_wen_drop", mem_wen, 0);
      send(8'hBB); send(8'hCC);
      frame_close();
      chk("t1_nwr", wq16.size(), 3);
      exp_wr16("t1_w0", 0, 16'h0100, 8'hAA);
      exp_wr16("t1_w1", 1, 16'h0101, 8'hBB);
      exp_wr16("t1_w2", 2, 16'h0102, 8'hCC);
      chk("t1_wen_cyc", wen_cycles - base, 3);
      chk("t1_err", ml_err, 0);

      // Address wrap at both widths
      clear_q();
      frame(5, 8'h20, 8'hFF, 8'hFF, 8'h11, 8'h22);
      chk("t2_nwr16", wq16.size(), 2);
      exp_wr16("t2_w16_0", 0, 16'hFFFF, 8'h11);
      exp_wr16("t2_w16_1", 1, 16'h0000, 8'h22);
      chk("t2_nwr12", wq12.size(), 2);
      exp_wr12("t2_w12_0", 0, 16'h0FFF, 8'h11);
      exp_wr12("t2_w12_1", 1, 16'h0000, 8'h22);

      // Run request, write-while-busy, done, clear
      frame_open();
      send(8'h21); send(8'h12);
      din_valid = 1'b1; din_data = 8'h34;
      tick();
      chk("t3_run", run_start, 1);
      chk("t3_raddr", run_addr, 16'h1234);
      chk("t3_rdy_lo", ml_rdy, 0);
      din_valid = 1'b0;
      tick();
      chk("t3_run_w", run_start, 0);
      frame_close();
      clear_q();
      frame(4, 8'h20, 8'h00, 8'h00, 8'h99);
      chk("t3_busy_nwr", wq16.size(), 0);
      chk("t3_busy_wen", wen_cycles - base, 0);
      chk("t3_busy_err", ml_err, 1);
      pulse_done();
      chk("t3_rdy_hi", ml_rdy, 1);
      frame(1, 8'h22);
      chk("t3_clr", ml_err, 0);

      // Stalled memory: second byte dropped, third lands at base+1
      mem_ready = 1'b0;
      clear_q();
      frame_open();
      send(8'h20); send(8'h02); send(8'h00);
      send(8'hA1);
      send(8'hA2);
      repeat (6) tick();
      chk("t4_hold_wen", mem_wen, 1);
      chk("t4_hold_addr", mem_addr, 16'h0200);
      chk("t4_hold_data", mem_wdata, 8'hA1);
      chk("t4_drop_err", ml_err, 1);
      mem_ready = 1'b1;
      tick();
      chk("t4_acc_wen", mem_wen, 0);
      send(8'hA3);
      frame_close();
      chk("t4_nwr", wq16.size(), 2);
      exp_wr16("t4_w0", 0, 16'h0200, 8'hA1);
      exp_wr16("t4_w1", 1, 16'h0201, 8'hA3);
      frame(1, 8'h22);

      // Illegal opcode; remainder of frame ignored
      clear_q();
      frame_open();
      din_valid = 1'b1; din_data = 8'h7F;
      tick();
      chk("t5_err_lat", ml_err, 1);
      din_valid = 1'b0;
      tick();
      send(8'h20); send(8'h00); send(8'h05); send(8'h66);
      frame_close();
      chk("t5_nwr", wq16.size(), 0);
      chk("t5_err", ml_err, 1);
      frame(1, 8'h22);
      chk("t5_clr", ml_err, 0);

      // Truncated header is dropped silently
      clear_q();
      frame(2, 8'h20, 8'h01);
      frame(4, 8'h20, 8'h00, 8'h10, 8'h55);
      chk("t6_nwr", wq16.size(), 1);
      exp_wr16("t6_w0", 0, 16'h0010, 8'h55);
      chk("t6_err", ml_err, 0);

      // Run frame with a trailing byte
      frame(4, 8'h21, 8'h00, 8'h40, 8'h77);
      chk("t7_err", ml_err, 1);
      chk("t7_busy", ml_rdy, 0);
      pulse_done();
      frame(1, 8'h22);
      chk("t7_clr", ml_err, 0);
      chk("t7_rdy", ml_rdy, 1);

      // Asynchronous reset with a pending write and a busy engine
      mem_ready = 1'b0;
      frame(4, 8'h20, 8'h03, 8'h00, 8'h5A);
      chk("t8_pend", mem_wen, 1);
      frame(3, 8'h21, 8'h0A, 8'hBC);
      chk("t8_busy", ml_rdy, 0);
      chk("t8_raddr", run_addr, 16'h0ABC);
      frame_open();
      #2 resetn = 1'b0;
      #1;
      chk("t8_wen",   mem_wen,   0);
      chk("t8_addr",  mem_addr,  0);
      chk("t8_wdata", mem_wdata, 0);
      chk("t8_run",   run_start, 0);
      chk("t8_raddr0", run_addr, 0);
      chk("t8_rdy",   ml_rdy,    1);
      chk("t8_err",   ml_err,    0);
      chk("t8_wen12", w12_wen,   0);
      tick();
      frame_active = 1'b0;
      mem_ready    = 1'b1;
      resetn       = 1'b1;
      tick();
      clear_q();
      frame(4, 8'h20, 8'h00, 8'h20, 8'hC3);
      chk("t8_nwr", wq16.size(), 1);
      exp_wr16("t8_w0", 0, 16'h0020, 8'hC3);
      chk("t8_err_after", ml_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
